player_input_encoder: RTL and testbench

//   Upstream stage of gameLogic. Turns raw per-player buttons into the 3-bit action codes that gameLogic consumes on player1/player2.

---
 rtl/game_pkg.sv | 37 +++
 rtl/player_input_encoder_if.sv | 30 +++
 rtl/player_input_encoder_debouncer.sv | 51 +++++
 rtl/player_input_encoder.sv | 92 +++++++++
 tb/tb_player_input_encoder.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared action codes and button indices for the player input path and gameLogic.
package game_pkg;

  localparam int unsigned NUM_BTNS = 5;

  localparam int unsigned BTN_PUNCH = 0;
  localparam int unsigned BTN_KICK  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_JUMP  = 4;

  localparam logic [2:0] ACT_WAIT  = 3'b000;
  localparam logic [2:0] ACT_PUNCH = 3'b001;
  localparam logic [2:0] ACT_KICK  = 3'b010;
  localparam logic [2:0] ACT_LEFT  = 3'b011;
  localparam logic [2:0] ACT_RIGHT = 3'b100;
  localparam logic [2:0] ACT_JUMP  = 3'b101;

  // Fixed priority: punch > kick > jump > left > right.
  function automatic logic [2:0] encode_action(input logic [NUM_BTNS-1:0] pend);
    logic [2:0] act;
    act = ACT_WAIT;
    if (pend[BTN_PUNCH]) begin
      act = ACT_PUNCH;
    end else if (pend[BTN_KICK]) begin
      act = ACT_KICK;
    end else if (pend[BTN_JUMP]) begin
      act = ACT_JUMP;
    end else if (pend[BTN_LEFT]) begin
      act = ACT_LEFT;
    end else if (pend[BTN_RIGHT]) begin
      act = ACT_RIGHT;
    end
    return act;
  endfunction

endpackage

// File: rtl/player_input_encoder_if.sv
// Button inputs, game_over and per-tick action outputs of the player input encoder.
interface player_input_encoder_if;
  import game_pkg::*;

  logic [NUM_BTNS-1:0] p1_buttons;
  logic [NUM_BTNS-1:0] p2_buttons;
  logic                game_over;
  logic [2:0]          player1_action;
  logic [2:0]          player2_action;
  logic                action_tick;

  modport master (
    output p1_buttons,
    output p2_buttons,
    output game_over,
    input  player1_action,
    input  player2_action,
    input  action_tick
  );

  modport slave (
    input  p1_buttons,
    input  p2_buttons,
    input  game_over,
    output player1_action,
    output player2_action,
    output action_tick
  );

endinterface

// File: rtl/player_input_encoder_debouncer.sv
// One button: two-flop synchroniser, stability counter, debounced level and rising-edge pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            level_prev_q;
  logic            synced;

  assign synced = sync_q[1];

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (synced == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = synced;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], raw};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign rise = level_q & ~level_prev_q;

endmodule

// File: rtl/player_input_encoder.sv
// Debounces both players' buttons, latches press edges as pending requests and issues
// one prioritised action per player on each game tick.
module player_input_encoder
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TICK_DIV        = 8
) (
  input logic                  clock,
  input logic                  reset,
  player_input_encoder_if.slave bus
);

  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

  logic [NUM_BTNS-1:0] p1_rise, p2_rise;
  logic [NUM_BTNS-1:0] p1_pend_q, p1_pend_d;
  logic [NUM_BTNS-1:0] p2_pend_q, p2_pend_d;
  logic [TickW-1:0]    tick_q, tick_d;
  logic [2:0]          act1_q, act1_d;
  logic [2:0]          act2_q, act2_d;
  logic                tick_out_q, tick_out_d;
  logic                tick;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_p1 (
      .clock(clock),
      .reset(reset),
      .raw  (bus.p1_buttons[i]),
      .rise (p1_rise[i])
    );
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_p2 (
      .clock(clock),
      .reset(reset),
      .raw  (bus.p2_buttons[i]),
      .rise (p2_rise[i])
    );
  end

  assign tick = (tick_q == TickMax);

  always_comb begin
    tick_d     = tick ? '0 : tick_q + 1'b1;
    act1_d     = ACT_WAIT;
    act2_d     = ACT_WAIT;
    tick_out_d = 1'b0;
    p1_pend_d  = p1_pend_q | p1_rise;
    p2_pend_d  = p2_pend_q | p2_rise;
    if (tick) begin
      tick_out_d = 1'b1;
      // Issue from the pre-tick pending set; edges arriving on the tick carry to the next one.
      if (!bus.game_over) begin
        act1_d = encode_action(p1_pend_q);
        act2_d = encode_action(p2_pend_q);
      end
      p1_pend_d = p1_rise;
      p2_pend_d = p2_rise;
    end
    if (bus.game_over) begin
      p1_pend_d = '0;
      p2_pend_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_q     <= '0;
      p1_pend_q  <= '0;
      p2_pend_q  <= '0;
      act1_q     <= ACT_WAIT;
      act2_q     <= ACT_WAIT;
      tick_out_q <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      p1_pend_q  <= p1_pend_d;
      p2_pend_q  <= p2_pend_d;
      act1_q     <= act1_d;
      act2_q     <= act2_d;
      tick_out_q <= tick_out_d;
    end
  end

  assign bus.player1_action = act1_q;
  assign bus.player2_action = act2_q;
  assign bus.action_tick    = tick_out_q;

endmodule

// File: tb/tb_player_input_encoder.sv
// Scoreboard bench: tests push expected issued actions keyed by tick number; a negedge monitor
// checks every cycle's outputs against them.
module tb_player_input_encoder;
  import game_pkg::*;

  localparam int unsigned DebCycles = 4;
  localparam int unsigned TickDiv   = 8;

  typedef struct {
    int         tick;
    logic [2:0] a1;
    logic [2:0] a2;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #50 clock = ~clock;

  player_input_encoder_if bus ();

  player_input_encoder #(
    .DEBOUNCE_CYCLES(DebCycles),
    .TICK_DIV       (TickDiv)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   n = 0;
  bit   mon_en = 1'b0;

  // Edges since reset release; a tick is expected whenever n is a non-zero multiple of 8.
  always @(posedge clock) begin
    if (reset) n <= 0;
    else n <= n + 1;
  end

  always @(negedge clock) begin
    logic       exp_tick;
    logic [2:0] e1, e2;
    exp_t       e;
    if (mon_en) begin
      exp_tick = (n > 0) && (n % TickDiv == 0);
      e1 = ACT_WAIT;
      e2 = ACT_WAIT;
      if (exp_tick) begin
        while (sb_q.size() > 0 && sb_q[0].tick < n / TickDiv) begin
          e = sb_q.pop_front();
          total++;
          bad++;
          $display("FAIL sb_missed: expected tick %0d never issued (n=%0d)", e.tick, n);
        end
        if (sb_q.size() > 0 && sb_q[0].tick == n / TickDiv) begin
          e  = sb_q.pop_front();
          e1 = e.a1;
          e2 = e.a2;
        end
      end
      total++;
      if (bus.action_tick !== exp_tick) begin
        bad++;
        $display("FAIL mon_tick n=%0d: got %b want %b", n, bus.action_tick, exp_tick);
      end
      total++;
      if (bus.player1_action !== e1) begin
        bad++;
        $display("FAIL mon_p1 n=%0d: got %b want %b", n, bus.player1_action, e1);
      end
      total++;
      if (bus.player2_action !== e2) begin
        bad++;
        $display("FAIL mon_p2 n=%0d: got %b want %b", n, bus.player2_action, e2);
      end
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_phase(input int ph);
    int g;
    g = 0;
    while ((n % TickDiv) != ph && g < 20) begin
      step(1);
      g++;
    end
  endtask

  // Press seen at n0 sets pending 7 edges later; issue is at the next tick strictly after that.
  function automatic int issue_tick(input int n0);
    return (n0 + 7) / TickDiv + 1;
  endfunction

  task automatic check_drained(input string name);
    total++;
    if (sb_q.size() !== 0) begin
      bad++;
      $display("FAIL %s: scoreboard holds %0d entries, want 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    int first;
    bus.p1_buttons = '0;
    bus.p2_buttons = '0;
    bus.game_over  = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (bus.player1_action !== ACT_WAIT || bus.player2_action !== ACT_WAIT ||
          bus.action_tick !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: got p1=%b p2=%b tick=%b want 000 000 0",
                 bus.player1_action, bus.player2_action, bus.action_tick);
      end
      @(posedge clock);
    end
    #1;
    reset = 1'b0;
    first = 0;
    for (int i = 1; i <= 12 && first == 0; i++) begin
      step(1);
      if (bus.action_tick === 1'b1) first = i;
    end
    total++;
    if (first !== 8) begin
      bad++;
      $display("FAIL first_tick: got clock %0d want 8", first);
    end
    total++;
    if (bus.player1_action !== ACT_WAIT || bus.player2_action !== ACT_WAIT) begin
      bad++;
      $display("FAIL first_tick_actions: got %b %b want 000 000",
               bus.player1_action, bus.player2_action);
    end
  endtask

  task automatic test_directions();
    int n0;
    step(3);
    n0 = n;
    bus.p1_buttons[BTN_RIGHT] = 1'b1;
    bus.p2_buttons[BTN_LEFT]  = 1'b1;
    sb_q.push_back('{tick: issue_tick(n0), a1: ACT_RIGHT, a2: ACT_LEFT});
    step(20);
    bus.p1_buttons = '0;
    bus.p2_buttons = '0;
    step(16);
    check_drained("directions");
  endtask

  task automatic test_glitch();
    bus.p1_buttons[BTN_PUNCH] = 1'b1;
    step(2);
    bus.p1_buttons = '0;
    for (int i = 0; i < 26; i++) begin
      step(1);
      total++;
      if (bus.player1_action !== ACT_WAIT) begin
        bad++;
        $display("FAIL glitch: got p1=%b want 000", bus.player1_action);
      end
    end
  endtask

  task automatic test_priority();
    int n0;
    wait_phase(2);
    n0 = n;
    bus.p1_buttons[BTN_PUNCH] = 1'b1;
    sb_q.push_back('{tick: issue_tick(n0), a1: ACT_PUNCH, a2: ACT_WAIT});
    step(1);
    bus.p1_buttons[BTN_KICK] = 1'b1;
    step(20);
    bus.p1_buttons = '0;
    step(16);
    check_drained("priority");
  endtask

  task automatic test_back_to_back();
    int n0;
    wait_phase(1);
    n0 = n;
    bus.p2_buttons[BTN_JUMP] = 1'b1;
    sb_q.push_back('{tick: issue_tick(n0), a1: ACT_WAIT, a2: ACT_JUMP});
    step(7);
    total++;
    if (bus.action_tick !== 1'b1 || bus.player2_action !== ACT_WAIT) begin
      bad++;
      $display("FAIL edge_on_tick: got tick=%b p2=%b want 1 000",
               bus.action_tick, bus.player2_action);
    end
    step(13);
    bus.p2_buttons = '0;
    step(16);
    check_drained("edge_on_tick_carry");
  endtask

  task automatic test_game_over();
    wait_phase(0);
    bus.p1_buttons[BTN_KICK] = 1'b1;
    step(7);
    bus.game_over = 1'b1;
    step(1);
    total++;
    if (bus.action_tick !== 1'b1 || bus.player1_action !== ACT_WAIT) begin
      bad++;
      $display("FAIL game_over_tick: got tick=%b p1=%b want 1 000",
               bus.action_tick, bus.player1_action);
    end
    step(1);
    bus.game_over  = 1'b0;
    bus.p1_buttons = '0;
    step(16);
    check_drained("game_over");
  endtask

  task automatic test_reset_mid();
    bus.p2_buttons[BTN_PUNCH] = 1'b1;
    step(3);
    reset = 1'b1;
    bus.p2_buttons = '0;
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      total++;
      if (bus.player2_action !== ACT_WAIT) begin
        bad++;
        $display("FAIL reset_mid: got p2=%b want 000", bus.player2_action);
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directions();
    test_glitch();
    test_priority();
    test_back_to_back();
    test_game_over();
    test_reset_mid();
    check_drained("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
